// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: load alignment/extension, rdata hold across WB stalls.
// Optional macro MS_FWD_BUS_EN: drive final_result onto the ID forward bus (otherwise hazard-only).
module mem_stage #(
    parameter int unsigned ES_TO_MS_BUS_WD = 106,
    parameter int unsigned MS_TO_WS_BUS_WD = 70,
    parameter int unsigned MS_FWD_BUS_WD   = 38
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FWD_BUS_WD-1:0]   ms_to_ds_fwd_bus
);

    logic                       ms_valid;
    logic                       ms_ready_go;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
    logic                       hold_vld;
    logic [31:0]                hold_data;

    logic [2:0]  ld_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rt_value;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic [1:0]  addr_lo;
    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ld_type      = es_to_ms_bus_r[105:103];
    assign res_from_mem = es_to_ms_bus_r[102];
    assign gr_we        = es_to_ms_bus_r[101];
    assign dest         = es_to_ms_bus_r[100:96];
    assign rt_value     = es_to_ms_bus_r[95:64];
    assign alu_result   = es_to_ms_bus_r[63:32];
    assign pc           = es_to_ms_bus_r[31:0];

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // Pipeline register plus capture of the SRAM word on the first stalled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid       <= 1'b0;
            es_to_ms_bus_r <= '0;
            hold_vld       <= 1'b0;
            hold_data      <= 32'h0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                es_to_ms_bus_r <= es_to_ms_bus;
            end
            if (ms_allowin) begin
                hold_vld <= 1'b0;
            end else if (ms_valid && !ws_allowin && !hold_vld) begin
                hold_vld  <= 1'b1;
                hold_data <= data_sram_rdata;
            end
        end
    end

    assign addr_lo  = alu_result[1:0];
    assign word     = hold_vld ? hold_data : data_sram_rdata;
    assign byte_sel = word[{addr_lo, 3'b000} +: 8];
    // Halfword select ignores addr_lo[0]; misalignment is trapped in EX.
    assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_data = word;
        case (ld_type)
            3'b001: load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b010: load_data = {24'h0, byte_sel};
            3'b011: load_data = {{16{half_sel[15]}}, half_sel};
            3'b100: load_data = {16'h0, half_sel};
            3'b101: begin
                case (addr_lo)
                    2'd0:    load_data = {word[7:0],  rt_value[23:0]};
                    2'd1:    load_data = {word[15:0], rt_value[15:0]};
                    2'd2:    load_data = {word[23:0], rt_value[7:0]};
                    default: load_data = word;
                endcase
            end
            3'b110: begin
                case (addr_lo)
                    2'd0:    load_data = word;
                    2'd1:    load_data = {rt_value[31:24], word[31:8]};
                    2'd2:    load_data = {rt_value[31:16], word[31:16]};
                    default: load_data = {rt_value[31:8],  word[31:24]};
                endcase
            end
            default: load_data = word;
        endcase
    end

    assign final_result = res_from_mem ? load_data : alu_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

`ifdef MS_FWD_BUS_EN
    assign ms_to_ds_fwd_bus = {ms_valid && gr_we, dest, final_result};
`else
    assign ms_to_ds_fwd_bus = {ms_valid && gr_we, dest, 32'h0};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors plus randomized traffic vs a transaction model.
// Honours MS_FWD_BUS_EN when computing the expected forward-bus data field.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [105:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [69:0]  ms_to_ws_bus;
    logic [31:0]  data_sram_rdata;
    logic [37:0]  ms_to_ds_fwd_bus;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model of the instruction held in MS.
    logic         m_occ   = 1'b0;
    logic [105:0] m_bus   = '0;
    logic         m_first = 1'b0;
    logic [31:0]  m_word  = '0;
    logic [31:0]  delivered[$];

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .ms_allowin       (ms_allowin),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .ws_allowin       (ws_allowin),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .data_sram_rdata  (data_sram_rdata),
        .ms_to_ds_fwd_bus (ms_to_ds_fwd_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [105:0] mk(input logic [2:0] ld, input logic rfm, input logic we,
                                        input logic [4:0] dst, input logic [31:0] rt,
                                        input logic [31:0] alu, input logic [31:0] pcv);
        return {ld, rfm, we, dst, rt, alu, pcv};
    endfunction

    // Load result from the memory-semantics view: shifts and masks on the word.
    function automatic logic [31:0] ref_load(input int t, input int a, input logic [31:0] w,
                                             input logic [31:0] rt);
        logic [31:0] b, h, msk;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (t)
            1: return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            2: return b;
            3: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            4: return h;
            5: begin
                msk = (a == 3) ? 32'h0 : (32'hFFFFFFFF >> (8 * (a + 1)));
                return (w << (8 * (3 - a))) | (rt & msk);
            end
            6: begin
                msk = ~(32'hFFFFFFFF >> (8 * a));
                return (w >> (8 * a)) | (rt & msk);
            end
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [105:0] bus, input logic [31:0] w);
        if (bus[102]) return ref_load(int'(bus[105:103]), int'(bus[33:32]), w, bus[95:64]);
        return bus[63:32];
    endfunction

    function automatic logic [31:0] fwd_data(input logic [31:0] r);
`ifdef MS_FWD_BUS_EN
        return r;
`else
        return 32'h0 & r;
`endif
    endfunction

    task automatic chk(input string tag, input logic [105:0] obs, input logic [105:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then compare outputs against the model mid-cycle.
    task automatic step_begin(input logic esv, input logic [105:0] bus, input logic ws,
                              input logic [31:0] rd);
        logic [31:0] r;
        es_to_ms_valid  = esv;
        es_to_ms_bus    = bus;
        ws_allowin      = ws;
        data_sram_rdata = rd;
        @(negedge clk);
        chk("allowin", 106'(ms_allowin), 106'(!m_occ || ws));
        chk("ws_valid", 106'(ms_to_ws_valid), 106'(m_occ));
        if (m_occ) begin
            r = ref_result(m_bus, m_first ? rd : m_word);
            chk("ws_bus", 106'(ms_to_ws_bus), 106'({m_bus[101], m_bus[100:96], r, m_bus[31:0]}));
            chk("fwd_bus", 106'(ms_to_ds_fwd_bus), 106'({m_bus[101], m_bus[100:96], fwd_data(r)}));
        end else begin
            chk("fwd_we_idle", 106'(ms_to_ds_fwd_bus[37]), 106'(0));
        end
        if (ms_to_ws_valid && ws_allowin) delivered.push_back(ms_to_ws_bus[31:0]);
    endtask

    task automatic step_end();
        if (reset) begin
            m_occ = 1'b0;
        end else begin
            if (m_occ && m_first) begin
                m_word  = data_sram_rdata;
                m_first = 1'b0;
            end
            if (!m_occ || ws_allowin) begin
                m_occ = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    m_bus   = es_to_ms_bus;
                    m_first = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_check(input string tag, input logic [2:0] ld, input logic [1:0] a,
                              input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
        step_begin(1'b1, mk(ld, 1'b1, 1'b1, 5'd9, rt, {30'h04000000, a}, 32'hBFC00100), 1'b1, $urandom);
        step_end();
        step_begin(1'b0, '0, 1'b1, rd);
        chk(tag, 106'(ms_to_ws_bus[63:32]), 106'(exp));
        step_end();
    endtask

    initial begin
        reset           = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_allowin", 106'(ms_allowin), 106'(1));
        chk("rst_valid", 106'(ms_to_ws_valid), 106'(0));
        chk("rst_ws_bus", 106'(ms_to_ws_bus), 106'(0));
        chk("rst_fwd_bus", 106'(ms_to_ds_fwd_bus), 106'(0));
        reset = 1'b0;

        // ALU result passes through
        step_begin(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd8, 32'h0, 32'h12345678, 32'hBFC00010), 1'b1, $urandom);
        step_end();
        step_begin(1'b0, '0, 1'b1, $urandom);
        chk("addu_valid", 106'(ms_to_ws_valid), 106'(1));
        chk("addu_bus", 106'(ms_to_ws_bus), 106'({1'b1, 5'd8, 32'h12345678, 32'hBFC00010}));
        step_end();

        load_check("lb_a3", 3'd1, 2'd3, 32'h0, 32'h80FF0011, 32'hFFFFFF80);
        load_check("lbu_a2", 3'd2, 2'd2, 32'h0, 32'h80FF0011, 32'h000000FF);
        load_check("lhu_a2", 3'd4, 2'd2, 32'h0, 32'h80FF0011, 32'h000080FF);
        load_check("lh_a0", 3'd3, 2'd0, 32'h0, 32'h80FF8011, 32'hFFFF8011);
        load_check("lwl_a1", 3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD);
        load_check("lwr_a2", 3'd6, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122);
        load_check("rsv_lw", 3'd7, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h11223344);

        // lw stalled three cycles keeps the first-cycle word; exactly one transfer
        delivered.delete();
        step_begin(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd4, 32'h0, 32'h00001000, 32'hBFC00200), 1'b0, $urandom);
        step_end();
        step_begin(1'b0, '0, 1'b0, 32'hCAFEF00D);
        chk("stall_allowin0", 106'(ms_allowin), 106'(0));
        step_end();
        for (int i = 0; i < 2; i++) begin
            step_begin(1'b0, '0, 1'b0, 32'hDEADBEEF);
            chk("stall_hold", 106'(ms_to_ws_bus[63:32]), 106'(32'hCAFEF00D));
            chk("stall_allowin", 106'(ms_allowin), 106'(0));
            step_end();
        end
        step_begin(1'b0, '0, 1'b1, 32'hDEADBEEF);
        chk("release_data", 106'(ms_to_ws_bus[63:32]), 106'(32'hCAFEF00D));
        step_end();
        step_begin(1'b0, '0, 1'b1, 32'hDEADBEEF);
        step_end();
        chk("stall_single_xfer", 106'(delivered.size()), 106'(1));

        // Back-to-back: one transfer per cycle, in order
        delivered.delete();
        for (int i = 0; i < 4; i++) begin
            step_begin(1'b1, mk(3'(i), 1'(i % 2), 1'(i != 2), 5'(i + 1), $urandom, $urandom,
                                32'hBFC00300 + 32'(4 * i)), 1'b1, $urandom);
            step_end();
        end
        for (int i = 0; i < 2; i++) begin
            step_begin(1'b0, '0, 1'b1, $urandom);
            step_end();
        end
        chk("b2b_count", 106'(delivered.size()), 106'(4));
        for (int i = 0; i < 4 && i < delivered.size(); i++)
            chk("b2b_pc", 106'(delivered[i]), 106'(32'hBFC00300 + 32'(4 * i)));

        // Reset during a stall drops the in-flight instruction
        step_begin(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd7, 32'h0, 32'h0, 32'hBFC00400), 1'b0, $urandom);
        step_end();
        step_begin(1'b0, '0, 1'b0, 32'h2468ACE0);
        step_end();
        reset = 1'b1;
        step_begin(1'b0, '0, 1'b0, $urandom);
        step_end();
        reset = 1'b0;
        step_begin(1'b0, '0, 1'b0, $urandom);
        chk("rst_stall_valid", 106'(ms_to_ws_valid), 106'(0));
        step_end();
        load_check("post_rst_lw", 3'd0, 2'd0, 32'h0, 32'h13579BDF, 32'h13579BDF);

        // Randomized traffic with random WB back-pressure
        for (int n = 0; n < 400; n++) begin
            step_begin($urandom_range(0, 3) != 0,
                       mk(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 5'($urandom),
                          $urandom, $urandom, $urandom),
                       $urandom_range(0, 3) != 0, $urandom);
            step_end();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
